// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared lane/VRF geometry, request types and unit ids.
//  Revision    : 1.0
// ============================================================================
package core_pkg;

    localparam int unsigned NrLane        = 4;
    localparam int unsigned VRFWordWidthB = 8;

    typedef logic [8*VRFWordWidthB-1:0] vrf_data_t;
    typedef logic [VRFWordWidthB-1:0]   vrf_strb_t;
    typedef logic [15:0]                vlen_t;
    typedef logic [3:0]                 insn_id_t;
    typedef logic [4:0]                 vreg_t;

    typedef enum logic [1:0] {EW8 = 2'd0, EW16 = 2'd1, EW32 = 2'd2, EW64 = 2'd3} vew_e;
    typedef enum logic [1:0] {VFU_ALU = 2'd0, VFU_MUL = 2'd1, VLU = 2'd2, VSU = 2'd3} vfu_e;

    typedef struct packed {
        vew_e     vew_vd;
        vlen_t    vl;
        insn_id_t insn_id;
        vreg_t    vd;
    } vfu_req_t;

endpackage
`default_nettype wire

// File: rtl/vlu_if.sv
`default_nettype none
// ============================================================================
//  Module      : vlu_if
//  Description : Launcher request, memory load and per-lane write-back bundle.
//  Revision    : 1.0
// ============================================================================
interface vlu_if;

    logic                                           vfu_req_valid_i;
    logic                                           vfu_req_ready_o;
    core_pkg::vfu_e                                 target_vfu_i;
    core_pkg::vfu_req_t                             vfu_req_i;
    logic                                           load_op_valid_i;
    logic                                           load_op_ready_o;
    core_pkg::vrf_data_t                            load_op_i;
    logic [core_pkg::NrLane-1:0]                    wb_valid_o;
    logic [core_pkg::NrLane-1:0]                    wb_ready_i;
    core_pkg::vrf_data_t [core_pkg::NrLane-1:0]     wb_data_o;
    core_pkg::vrf_strb_t [core_pkg::NrLane-1:0]     wb_strb_o;
    logic                                           done_o;
    core_pkg::insn_id_t                             done_insn_id_o;
    logic                                           insn_use_vd_o;
    core_pkg::vreg_t                                insn_vd_o;

    modport slave (
        input  vfu_req_valid_i, target_vfu_i, vfu_req_i,
        input  load_op_valid_i, load_op_i, wb_ready_i,
        output vfu_req_ready_o, load_op_ready_o,
        output wb_valid_o, wb_data_o, wb_strb_o,
        output done_o, done_insn_id_o, insn_use_vd_o, insn_vd_o
    );

    modport master (
        output vfu_req_valid_i, target_vfu_i, vfu_req_i,
        output load_op_valid_i, load_op_i, wb_ready_i,
        input  vfu_req_ready_o, load_op_ready_o,
        input  wb_valid_o, wb_data_o, wb_strb_o,
        input  done_o, done_insn_id_o, insn_use_vd_o, insn_vd_o
    );

endinterface
`default_nettype wire

// File: rtl/vlu.sv
`default_nettype none
// ============================================================================
//  Module      : vlu
//  Description : Vector load unit - stages memory words into lane groups,
//                shuffles elements across lanes and buffers per-lane writes.
//  Revision    : 1.0
// ============================================================================
module vlu
    import core_pkg::*;
#(
    parameter int unsigned InOpBufDepth = 4
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    vlu_if.slave      vlu_bus
);

    localparam int unsigned c_GROUP_B = NrLane * VRFWordWidthB;
    localparam int unsigned c_GB_W    = $clog2(c_GROUP_B);
    localparam int unsigned c_OPC_W   = (NrLane > 1) ? $clog2(NrLane) : 1;
    localparam int unsigned c_VLB_W   = $bits(vlen_t) + 4;
    localparam int unsigned c_PTR_W   = $clog2(InOpBufDepth);
    localparam int unsigned c_CNT_W   = $clog2(InOpBufDepth + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_en_sr;
    logic               w_out_en;
    logic [1:0]         r_vew;
    logic [c_VLB_W-1:0] r_vlb;
    logic [c_VLB_W-1:0] r_vlb_total;
    logic [c_VLB_W-1:0] r_byte_base;
    logic [c_VLB_W-1:0] w_req_vlb;
    insn_id_t           r_insn_id;
    vreg_t              r_vd;
    logic [c_OPC_W-1:0] r_op_cnt;
    logic               r_pending;
    logic               r_last_grp;
    vrf_data_t          r_stage [NrLane];
    logic [7:0]         w_gbytes [c_GROUP_B];

    logic               w_accept;
    logic               w_zero_vl;
    logic               w_load_fire;
    logic               w_last_word;
    logic               w_push;
    logic               w_req_ready;
    logic               w_load_ready;
    logic               w_done;
    logic [NrLane-1:0]  w_full;
    logic [NrLane-1:0]  w_empty;
    logic [NrLane-1:0]  w_wb_valid;
    vrf_data_t [NrLane-1:0] w_wb_data;
    vrf_strb_t [NrLane-1:0] w_wb_strb;

    // Outputs stay quiet while reset is held and for one full cycle after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_en_sr <= 2'b00;
        else       r_en_sr <= {r_en_sr[0], 1'b1};
    end
    assign w_out_en = r_en_sr[1];

    assign w_req_vlb   = c_VLB_W'(vlu_bus.vfu_req_i.vl) << vlu_bus.vfu_req_i.vew_vd;
    assign w_zero_vl   = (vlu_bus.vfu_req_i.vl == '0);
    assign w_accept    = (r_state == c_ST_IDLE) && w_out_en && vlu_bus.vfu_req_valid_i &&
                         (vlu_bus.target_vfu_i == VLU);
    assign w_load_fire = w_load_ready && vlu_bus.load_op_valid_i;
    assign w_last_word = (r_vlb <= c_VLB_W'(VRFWordWidthB));
    assign w_push      = (r_state == c_ST_LOAD) && r_pending && ~(|w_full);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_load_ready = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_req_ready = w_out_en;
                if (w_accept) w_state_nxt = w_zero_vl ? c_ST_DRAIN : c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_load_ready = ~r_pending;
                if (w_push && r_last_grp) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (&w_empty) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vew       <= '0;
            r_vlb       <= '0;
            r_vlb_total <= '0;
            r_byte_base <= '0;
            r_insn_id   <= '0;
            r_vd        <= '0;
            r_op_cnt    <= '0;
            r_pending   <= 1'b0;
            r_last_grp  <= 1'b0;
            for (int w = 0; w < NrLane; w++) r_stage[w] <= '0;
        end else begin
            if (w_accept) begin
                r_vew       <= vlu_bus.vfu_req_i.vew_vd;
                r_vlb       <= w_req_vlb;
                r_vlb_total <= w_req_vlb;
                r_byte_base <= '0;
                r_insn_id   <= vlu_bus.vfu_req_i.insn_id;
                r_vd        <= vlu_bus.vfu_req_i.vd;
                r_op_cnt    <= '0;
                r_pending   <= 1'b0;
                r_last_grp  <= 1'b0;
            end
            if (w_load_fire) begin
                for (int w = 0; w < NrLane; w++)
                    if (r_op_cnt == c_OPC_W'(w)) r_stage[w] <= vlu_bus.load_op_i;
                r_vlb <= w_last_word ? '0 : r_vlb - c_VLB_W'(VRFWordWidthB);
                if (w_last_word || (r_op_cnt == c_OPC_W'(NrLane - 1))) begin
                    r_pending  <= 1'b1;
                    r_last_grp <= w_last_word;
                    r_op_cnt   <= '0;
                end else begin
                    r_op_cnt <= r_op_cnt + 1'b1;
                end
            end
            // Clearing the staging slots keeps unfilled slots of a trailing partial group zero.
            if (w_push) begin
                r_pending   <= 1'b0;
                r_byte_base <= r_byte_base + c_VLB_W'(c_GROUP_B);
                for (int w = 0; w < NrLane; w++) r_stage[w] <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < c_GROUP_B; gi++) begin : g_flat
        assign w_gbytes[gi] = r_stage[gi / VRFWordWidthB][(gi % VRFWordWidthB)*8 +: 8];
    end

    for (genvar gl = 0; gl < NrLane; gl++) begin : g_lane
        vrf_data_t          w_data;
        vrf_strb_t          w_strb;
        vrf_data_t          r_mem_d [InOpBufDepth];
        vrf_strb_t          r_mem_s [InOpBufDepth];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_pop;

        // Lane byte gk sits in element slot gk>>vew, i.e. group element slot*NrLane+gl.
        for (genvar gk = 0; gk < VRFWordWidthB; gk++) begin : g_byte
            logic [c_GB_W-1:0] w_src;
            assign w_src = c_GB_W'(((((gk >> r_vew) * NrLane) + gl) << r_vew) +
                                   (gk & ((1 << r_vew) - 1)));
            assign w_data[gk*8 +: 8] = w_gbytes[w_src];
            assign w_strb[gk]        = (r_byte_base + c_VLB_W'(w_src)) < r_vlb_total;
        end

        assign w_full[gl]  = (r_cnt == c_CNT_W'(InOpBufDepth));
        assign w_empty[gl] = (r_cnt == '0);
        assign w_pop       = ~w_empty[gl] & vlu_bus.wb_ready_i[gl];

        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem_d[r_wptr] <= w_data;
                r_mem_s[r_wptr] <= w_strb;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push)
                    r_wptr <= (r_wptr == c_PTR_W'(InOpBufDepth - 1)) ? '0 : r_wptr + 1'b1;
                if (w_pop)
                    r_rptr <= (r_rptr == c_PTR_W'(InOpBufDepth - 1)) ? '0 : r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign w_wb_valid[gl] = ~w_empty[gl];
        assign w_wb_data[gl]  = w_empty[gl] ? '0 : r_mem_d[r_rptr];
        assign w_wb_strb[gl]  = w_empty[gl] ? '0 : r_mem_s[r_rptr];
    end

    assign vlu_bus.vfu_req_ready_o = w_req_ready;
    assign vlu_bus.load_op_ready_o = w_load_ready;
    assign vlu_bus.wb_valid_o      = w_wb_valid;
    assign vlu_bus.wb_data_o       = w_wb_data;
    assign vlu_bus.wb_strb_o       = w_wb_strb;
    assign vlu_bus.done_o          = w_done;
    assign vlu_bus.done_insn_id_o  = w_done ? r_insn_id : '0;
    assign vlu_bus.insn_use_vd_o   = w_done;
    assign vlu_bus.insn_vd_o       = w_done ? r_vd : '0;

endmodule
`default_nettype wire

// File: tb/tb_vlu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vlu
//  Description : Randomized scoreboard bench for the vector load unit.
//  Revision    : 1.0
// ============================================================================
module tb_vlu;
    import core_pkg::*;

    localparam int c_DEPTH = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    vlu_if vif ();

    vlu #(.InOpBufDepth(c_DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .vlu_bus (vif.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_done_cyc = -10;
    int   words_sent = 0;
    bit   tb_busy = 1'b0;
    bit   rst_win = 1'b1;
    bit   hold2 = 1'b0;
    bit   no_load_watch = 1'b0;
    logic [71:0] exp_q [NrLane][$];
    logic [8:0]  done_q[$];
    logic [63:0] words[$];
    logic [71:0] mon_e;
    logic [8:0]  mon_d;

    function automatic void chk(string nm, logic [71:0] act, logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        for (int l = 0; l < NrLane; l++)
            vif.wb_ready_i[l] = (hold2 && l == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk_i) begin
        if (rst_win) begin
            chk("reset_outputs", {64'd0, |vif.wb_valid_o, |vif.wb_data_o, |vif.wb_strb_o,
                vif.vfu_req_ready_o, vif.load_op_ready_o, vif.done_o, vif.insn_use_vd_o,
                |{vif.done_insn_id_o, vif.insn_vd_o}}, 72'd0);
        end else begin
            chk("req_ready", {71'd0, vif.vfu_req_ready_o}, {71'd0, !tb_busy});
            if (no_load_watch) chk("no_load_ready", {71'd0, vif.load_op_ready_o}, 72'd0);
            for (int l = 0; l < NrLane; l++) begin
                if (vif.wb_valid_o[l] && vif.wb_ready_i[l]) begin
                    if (exp_q[l].size() == 0) begin
                        chk("wb_unexpected", {64'd0, 8'(l)}, 72'hff);
                    end else begin
                        mon_e = exp_q[l].pop_front();
                        chk($sformatf("wb_lane%0d", l), {vif.wb_data_o[l], vif.wb_strb_o[l]}, mon_e);
                    end
                end
            end
            if (vif.done_o) begin
                last_done_cyc = cyc;
                tb_busy = 1'b0;
                chk("done_use_vd", {71'd0, vif.insn_use_vd_o}, 72'd1);
                chk("done_fifos_empty", {68'd0, vif.wb_valid_o}, 72'd0);
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 72'd1, 72'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_id_vd", {63'd0, vif.done_insn_id_o, vif.insn_vd_o}, {63'd0, mon_d});
                end
            end else begin
                chk("idle_done_fields", {62'd0, vif.insn_use_vd_o, vif.done_insn_id_o, vif.insn_vd_o}, 72'd0);
            end
        end
    end

    // Reference: element e of group g lands in lane e%NrLane, slot e/NrLane.
    task automatic build(input int vl, input int vew, input int id, input int vd, output vfu_req_t r, output int nw);
        int sew, ng, epg, e, gb, wi;
        logic [63:0] wl[$];
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  byt;
        sew = 1 << vew;
        nw  = (vl * sew + VRFWordWidthB - 1) / VRFWordWidthB;
        ng  = (nw + NrLane - 1) / NrLane;
        epg = (NrLane * VRFWordWidthB) / sew;
        for (int w = 0; w < nw; w++) begin
            wl.push_back({$urandom(), $urandom()});
            words.push_back(wl[w]);
        end
        for (int g = 0; g < ng; g++) begin
            for (int l = 0; l < NrLane; l++) begin
                data = '0;
                strb = '0;
                for (int s = 0; s < VRFWordWidthB / sew; s++) begin
                    e = s * NrLane + l;
                    for (int b = 0; b < sew; b++) begin
                        gb  = g * NrLane * VRFWordWidthB + e * sew + b;
                        wi  = gb / VRFWordWidthB;
                        byt = (wi < nw) ? wl[wi][(gb % VRFWordWidthB)*8 +: 8] : 8'd0;
                        data[(s*sew + b)*8 +: 8] = byt;
                        strb[s*sew + b] = ((g * epg + e) < vl);
                    end
                end
                exp_q[l].push_back({data, strb});
            end
        end
        done_q.push_back({id[3:0], vd[4:0]});
        r.vew_vd  = vew_e'(vew);
        r.vl      = vlen_t'(vl);
        r.insn_id = insn_id_t'(id);
        r.vd      = vreg_t'(vd);
    endtask

    task automatic issue(input vfu_req_t r);
        bit ok = 1'b0;
        @(posedge clk_i); #1;
        vif.vfu_req_valid_i = 1'b1;
        vif.target_vfu_i    = VLU;
        vif.vfu_req_i       = r;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk_i);
            if (vif.vfu_req_ready_o) begin
                ok = 1'b1;
                accept_cyc = cyc;
            end
            @(posedge clk_i); #1;
        end
        vif.vfu_req_valid_i = 1'b0;
        if (ok) tb_busy = 1'b1;
        else    chk("req_accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic drive(input int n);
        int idx = 0;
        for (int t = 0; t < 5000 && idx < n; t++) begin
            @(posedge clk_i); #1;
            vif.load_op_valid_i = ($urandom_range(0, 3) != 0) && (words.size() > 0);
            vif.load_op_i       = (words.size() > 0) ? words[0] : '0;
            @(negedge clk_i);
            if (vif.load_op_valid_i && vif.load_op_ready_o) begin
                void'(words.pop_front());
                idx++;
                words_sent++;
            end
        end
        @(posedge clk_i); #1;
        vif.load_op_valid_i = 1'b0;
        if (idx < n) chk("load_timeout", 72'(idx), 72'(n));
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_q.size() != 0 && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        if (done_q.size() != 0) chk("done_timeout", 72'(done_q.size()), 72'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        rst_win = 1'b1;
        tb_busy = 1'b0;
        for (int l = 0; l < NrLane; l++) exp_q[l].delete();
        done_q.delete();
        words.delete();
        vif.load_op_valid_i = 1'b0;
        vif.vfu_req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_win = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        vfu_req_t ra, rb;
        int na, nb, ws0;
        vif.vfu_req_valid_i = 1'b0;
        vif.target_vfu_i    = VFU_ALU;
        vif.vfu_req_i       = '0;
        vif.load_op_valid_i = 1'b0;
        vif.load_op_i       = '0;
        vif.wb_ready_i      = '0;
        do_reset();

        // Two full groups of 32-bit elements
        build(16, 2, 1, 3, ra, na);
        issue(ra); drive(na); wait_done();

        // Single partial group of bytes
        build(5, 0, 2, 4, ra, na);
        issue(ra); drive(na); wait_done();

        // Non-VLU target is ignored while ready stays high
        @(posedge clk_i); #1;
        vif.vfu_req_valid_i = 1'b1;
        vif.target_vfu_i    = VFU_ALU;
        repeat (4) @(posedge clk_i);
        #1 vif.vfu_req_valid_i = 1'b0;

        // vl == 0: done the cycle after acceptance, no memory word taken
        build(0, 3, 5, 6, ra, na);
        no_load_watch = 1'b1;
        issue(ra); wait_done();
        no_load_watch = 1'b0;
        chk("zero_vl_done_latency", 72'(last_done_cyc - accept_cyc), 72'd1);

        // Request offered while busy is held off until the cycle after done
        build(16, 1, 6, 7, ra, na);
        build(8, 3, 7, 8, rb, nb);
        issue(ra);
        fork
            drive(na);
            issue(rb);
        join
        chk("req_after_done", 72'(accept_cyc - last_done_cyc), 72'd1);
        drive(nb); wait_done();

        // Stalled lane 2 back-pressures the load port
        hold2 = 1'b1;
        build(64, 3, 9, 10, ra, na);
        issue(ra);
        ws0 = words_sent;
        fork
            drive(na);
            begin
                repeat (80) @(negedge clk_i);
                chk("stall_words_taken", 72'(words_sent - ws0), 72'(3 * NrLane));
                chk("stall_load_ready", {71'd0, vif.load_op_ready_o}, 72'd0);
                hold2 = 1'b0;
            end
        join
        wait_done();

        // Reset in the middle of a load drops the instruction
        build(32, 3, 11, 12, ra, na);
        issue(ra); drive(3);
        do_reset();
        build(4, 3, 12, 13, ra, na);
        issue(ra); drive(na); wait_done();

        for (int i = 0; i < 6; i++) begin
            build($urandom_range(1, 48), $urandom_range(0, 3), i + 1, i + 20, ra, na);
            issue(ra); drive(na); wait_done();
        end

        for (int l = 0; l < NrLane; l++) chk("lane_queue_drained", 72'(exp_q[l].size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
